// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, field widths and the
// writeback FSM state type.
package mips_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [5:0] OP_LW = 6'b100011;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_t;

    // True when the opcode is a word load that must wait for memory data.
    function automatic logic is_load(input logic [5:0] opcode);
        return (opcode == OP_LW);
    endfunction

endpackage

// File: rtl/writeback_unit.sv
// Writeback stage: accepts completed instructions, waits for load data,
// and drives the register file's single write port with one registered
// write per instruction. Flags abandoned loads and counts retirements.
//
// Handshake: an instruction transfers on a rising edge where
// in_valid && in_ready; in_ready depends only on the FSM state, never on
// in_valid, and in_valid is never required to wait for in_ready.
module writeback_unit
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          in_opcode,
    input  logic [REG_AW-1:0]   in_rt,
    input  logic [REG_AW-1:0]   in_rd,
    input  logic                in_regwrite,
    input  logic [DATA_W-1:0]   in_aluresult,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                wb_we,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic                err_timeout,
    output logic [31:0]         retired
);

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    wb_state_t           state_q,   state_d;
    logic [REG_AW-1:0]   rt_q,      rt_d;
    logic [7:0]          tmo_cnt_q, tmo_cnt_d;
    logic                wb_we_q,   wb_we_d;
    logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                err_q,     err_d;
    logic [31:0]         retired_q, retired_d;

    logic                accept;
    logic [7:0]          tmo_next;

    // Ready is a pure state decode so upstream sees no combinational path.
    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign tmo_next = tmo_cnt_q + 8'd1;

    // Next-state, write-port and counter logic; everything defaults to hold,
    // and the write enable defaults low so it can only pulse for one cycle.
    always_comb begin
        state_d   = state_q;
        rt_d      = rt_q;
        tmo_cnt_d = tmo_cnt_q;
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;
        retired_d = retired_q;

        unique case (state_q)
            ST_IDLE: begin
                // Memory responses arriving here belong to nothing and are dropped.
                if (accept) begin
                    if (is_load(in_opcode)) begin
                        rt_d      = in_rt;
                        tmo_cnt_d = 8'd0;
                        state_d   = ST_WAIT_MEM;
                    end else begin
                        retired_d = retired_q + 32'd1;
                        if (in_regwrite) begin
                            wb_addr_d = in_rd;
                            wb_data_d = in_aluresult;
                            // r0 is hardwired zero; the instruction still retires.
                            wb_we_d   = (in_rd != '0);
                        end
                    end
                end
            end

            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    wb_addr_d = rt_q;
                    wb_data_d = mem_rdata;
                    wb_we_d   = (rt_q != '0);
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_next;
                    // Abandon after MEM_TIMEOUT silent waiting edges: no write, no retire.
                    if (tmo_next == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rt_q      <= '0;
            tmo_cnt_q <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            rt_q      <= rt_d;
            tmo_cnt_q <= tmo_cnt_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    assign wb_we       = wb_we_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign err_timeout = err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a write-port scoreboard.
module tb_writeback_unit;
    import mips_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_opcode = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic        in_regwrite = 1'b0;
    logic [31:0] in_aluresult = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_timeout;
    logic [31:0] retired;

    writeback_unit #(.MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_regwrite  (in_regwrite),
        .in_aluresult (in_aluresult),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .err_timeout  (err_timeout),
        .retired      (retired)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];   // {addr[4:0], data[31:0]}

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {wb_addr, wb_data}, 37'h0);
                total--;          // chk counted it; keep the count as one comparison
                total++;
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("write_port", {wb_addr, wb_data}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res, input logic rw);
        in_valid     = 1'b1;
        in_opcode    = 6'b000000;
        in_rd        = rd;
        in_rt        = 5'd0;
        in_regwrite  = rw;
        in_aluresult = res;
        if (rw && rd != 5'd0) exp_q.push_back({rd, res});
    endtask

    task automatic drive_load(input logic [4:0] rt);
        in_valid     = 1'b1;
        in_opcode    = OP_LW;
        in_rt        = rt;
        in_rd        = 5'd0;
        in_regwrite  = 1'b1;   // ignored for loads
        in_aluresult = 32'hFFFF_0000;
    endtask

    task automatic idle_in();
        in_valid    = 1'b0;
        in_regwrite = 1'b0;
        in_opcode   = '0;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] ret_snap;

    initial begin
        // Reset state
        #1;
        chk("rst_we",      {36'h0, wb_we},       37'h0);
        chk("rst_addr",    {32'h0, wb_addr},     37'h0);
        chk("rst_data",    {5'h0, wb_data},      37'h0);
        chk("rst_err",     {36'h0, err_timeout}, 37'h0);
        chk("rst_retired", {5'h0, retired},      37'h0);
        chk("rst_ready",   {36'h0, in_ready},    37'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single ALU op to r5
        @(negedge clk);
        drive_alu(5'd5, 32'h0000_0012, 1'b1);
        @(negedge clk);
        idle_in();
        chk("alu_we",      {36'h0, wb_we}, 37'h1);
        chk("alu_retired", {5'h0, retired}, 37'd1);
        @(negedge clk);
        chk("alu_we_once", {36'h0, wb_we}, 37'h0);

        // Load r9; a memory pulse on the accept cycle must be ignored
        @(negedge clk);
        drive_load(5'd9);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        idle_in();
        mem_rvalid = 1'b0;
        chk("ld_ready_wait", {36'h0, in_ready}, 37'h0);
        exp_q.push_back({5'd9, 32'hDEAD_BEEF});
        @(negedge clk);
        @(negedge clk);
        chk("ld_ready_wait2", {36'h0, in_ready}, 37'h0);
        chk("ld_no_early_we", {36'h0, wb_we},    37'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("ld_we",        {36'h0, wb_we},    37'h1);
        chk("ld_ready_back",{36'h0, in_ready}, 37'h1);
        chk("ld_retired",   {5'h0, retired},   37'd2);

        // Load with no response: abandoned after 16 waiting edges
        @(negedge clk);
        ret_snap = retired;
        drive_load(5'd7);
        @(negedge clk);
        idle_in();
        repeat (15) @(negedge clk);
        chk("tmo_ready_15", {36'h0, in_ready},    37'h0);
        chk("tmo_err_15",   {36'h0, err_timeout}, 37'h0);
        @(negedge clk);
        chk("tmo_ready_16", {36'h0, in_ready},    37'h1);
        chk("tmo_err_16",   {36'h0, err_timeout}, 37'h1);
        chk("tmo_retired",  {5'h0, retired},      {5'h0, ret_snap});
        // Late response after abandon is ignored, error stays sticky
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("tmo_err_sticky", {36'h0, err_timeout}, 37'h1);

        // Back-to-back ALU ops to r3, r0, r4 with random data
        ret_snap = retired;
        @(negedge clk);
        drive_alu(5'd3, $urandom_range(32'h7FFF_FFFF, 1), 1'b1);
        @(negedge clk);
        drive_alu(5'd0, $urandom_range(32'h7FFF_FFFF, 1), 1'b1);
        @(negedge clk);
        drive_alu(5'd4, $urandom_range(32'h7FFF_FFFF, 1), 1'b1);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        chk("b2b_retired", {5'h0, retired}, {5'h0, ret_snap + 32'd3});

        // Non-writing ALU op still retires
        ret_snap = retired;
        drive_alu(5'd6, 32'h0000_00AA, 1'b0);
        @(negedge clk);
        idle_in();
        chk("nowr_retired", {5'h0, retired}, {5'h0, ret_snap + 32'd1});

        // Reset two cycles into a load wait
        @(negedge clk);
        drive_load(5'd11);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready",   {36'h0, in_ready},    37'h1);
        chk("mid_rst_err",     {36'h0, err_timeout}, 37'h0);
        chk("mid_rst_retired", {5'h0, retired},      37'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_we",   {36'h0, wb_we},   37'h0);
        chk("post_rst_addr", {32'h0, wb_addr}, 37'h0);
        chk("post_rst_data", {5'h0, wb_data},  37'h0);
        chk("post_rst_ret",  {5'h0, retired},  37'h0);

        // Retired counter wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        chk("wrap_preload", {5'h0, retired}, {5'h0, 32'hFFFF_FFFF});
        drive_alu(5'd2, 32'h0000_0777, 1'b1);
        @(negedge clk);
        idle_in();
        chk("wrap_retired", {5'h0, retired}, 37'h0);

        // Drain and final report
        repeat (3) @(negedge clk);
        chk("exp_q_empty", 37'(exp_q.size()), 37'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the 32-bit MIPS pipeline: the write-side partner of the register block. Accepts completed instructions from the ALU/memory stage, waits for load data from the memory block, and drives the register block's single write port with one registered write per instruction. Also flags memory-response timeouts and counts retired instructions.

## Interface

Parameters:
- MEM_TIMEOUT, 16: max cycles spent in WAIT_MEM before abandoning a load (range 2..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream instruction present.
- in_ready  output  1  unit can accept; transfer occurs when in_valid && in_ready on a rising edge.
- in_opcode  input  6  instruction opcode.
- in_rt  input  5  rt field; load destination.
- in_rd  input  5  rd field; ALU-write destination.
- in_regwrite  input  1  instruction writes rd with the ALU result.
- in_aluresult  input  32  ALU result.
- mem_rvalid  input  1  load data valid; single-cycle pulse from the memory block.
- mem_rdata  input  32  load data.
- wb_we  output  1  register write enable; one-cycle pulse.
- wb_addr  output  5  register write address.
- wb_data  output  32  register write data.
- err_timeout  output  1  sticky; set when a load is abandoned.
- retired  output  32  count of completed instructions.

## Operation

- FSM states: IDLE, WAIT_MEM.
- IDLE: in_ready=1.
  - Accepted load (in_opcode == OP_LW): latch in_rt, clear timeout counter, go to WAIT_MEM. in_regwrite is ignored for loads.
  - Accepted non-load with in_regwrite=1: next cycle wb_we=1, wb_addr=in_rd, wb_data=in_aluresult. Stay in IDLE; back-to-back accepts allowed.
  - Accepted non-load with in_regwrite=0: no write; retired still increments.
- WAIT_MEM: in_ready=0.
  - mem_rvalid=1: next cycle wb_we=1, wb_addr=latched rt, wb_data=mem_rdata. Return to IDLE.
  - Otherwise the timeout counter increments. When it reaches MEM_TIMEOUT with no mem_rvalid, set err_timeout, return to IDLE, perform no write, and do not increment retired.
- mem_rvalid is sampled only in WAIT_MEM. A pulse in IDLE, including on the cycle a load is accepted, is ignored.
- Writes to address 0 are suppressed (wb_we stays 0), but the instruction still retires.
- retired increments by 1 per completed instruction and wraps from 0xFFFFFFFF to 0.
- err_timeout clears only on reset.

## Timing

- Reset values: wb_we=0, wb_addr=0, wb_data=0, err_timeout=0, retired=0, state=IDLE, in_ready=1.
- All outputs except in_ready are registered. in_ready is decoded from state.
- Non-load latency: accept at edge N → wb_we high for cycle N+1.
- Load latency: mem_rvalid sampled at edge M → wb_we high for cycle M+1. in_ready=1 from cycle M+1.
- wb_we is never high for two cycles from the same instruction.
- Timeout abandon: in_ready returns to 1 in the cycle after the MEM_TIMEOUT-th waiting edge.
- retired updates in the same cycle wb_we would assert.
- Reset asserted mid-load: return to IDLE immediately, drop any pending write, clear retired and err_timeout.

## Structure

- Shared package mips_pkg: OP_LW = 6'b100011, register address width (5), data width (32), FSM state typedef wb_state_t.
- Single module. The timeout counter is an inline 8-bit counter, not a sub-module.

## Test plan

- Reset, then ALU op in_rd=5, in_aluresult=0x0000_0012, in_regwrite=1 → wb_we=1, wb_addr=5, wb_data=0x12 one cycle after accept; retired=1.
- Load in_rt=9, mem_rvalid with 0xDEAD_BEEF three cycles later → in_ready=0 while waiting; wb_we=1, wb_addr=9, wb_data=0xDEADBEEF one cycle after mem_rvalid.
- Load with no mem_rvalid, MEM_TIMEOUT=16 → err_timeout=1 after 16 waiting cycles, no wb_we, retired unchanged, in_ready=1 again.
- Back-to-back ALU ops to r3, r0, r4 → write pulses for r3 and r4 only; retired=3.
- rst_n low two cycles into a load wait, then a mem_rvalid pulse after release → no write; all outputs at reset values.
- Preload retired to 0xFFFFFFFF via 2^32−1 retirements (forced) then one more retirement → retired=0.
